// File: rtl/clo_normalizer_pkg.sv
// Shared types for the iterative leading-bit normalizer.
package clo_normalizer_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  lzcount_t;

    typedef enum logic [1:0] {
        NORM_IDLE,
        NORM_RUN,
        NORM_DONE
    } norm_state_t;

    // Logical left shift that yields zero for amounts of 32 or more.
    function automatic word_t shl_fill0(input word_t val, input lzcount_t amt);
        if (amt >= 6'd32) return '0;
        return val << amt[4:0];
    endfunction

endpackage

// File: rtl/clo_normalizer_if.sv
// Request/result bundle between the execute stage and the normalizer.
interface clo_normalizer_if;
    import clo_normalizer_pkg::*;

    logic     start;
    logic     mode;
    word_t    in;
    logic     flush;
    logic     ready;
    logic     done;
    lzcount_t count;
    word_t    norm;

    modport master (
        output start, mode, in, flush,
        input  ready, done, count, norm
    );

    modport slave (
        input  start, mode, in, flush,
        output ready, done, count, norm
    );

endinterface

// File: rtl/clo_normalizer_lead_match.sv
// Counts MSB-first bits of a small window that equal the target bit.
module lead_match_window
    import clo_normalizer_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] bits,
    input  logic         tgt,
    output lzcount_t     count
);

    logic run;

    always_comb begin
        count = '0;
        run   = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            if (run && (bits[i] == tgt)) begin
                count = count + 6'd1;
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/clo_normalizer.sv
// Leading ones/zeros normalizer: STEP bits examined and shifted out per RUN cycle.
//   state     | meaning
//   NORM_IDLE | ready for a new operand, last result held on count/norm
//   NORM_RUN  | stripping leading target bits from shreg
//   NORM_DONE | result presented with a one-cycle done pulse
module clo_normalizer
    import clo_normalizer_pkg::*;
#(
    parameter int STEP = 1
) (
    input logic               clk,
    input logic               reset,
    clo_normalizer_if.slave   bus
);

    localparam lzcount_t STEP_L = lzcount_t'(STEP);

    norm_state_t state_q, state_d;
    word_t       shreg_q, shreg_d;
    lzcount_t    cnt_q, cnt_d;
    logic        tgt_q, tgt_d;
    lzcount_t    count_q, count_d;
    word_t       norm_q, norm_d;
    lzcount_t    win_cnt;
    logic        done_now;

    lead_match_window #(.W(STEP)) u_window (
        .bits  (shreg_q[31:32-STEP]),
        .tgt   (tgt_q),
        .count (win_cnt)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        count_d = count_q;
        norm_d  = norm_q;
        case (state_q)
            NORM_IDLE: begin
                if (bus.start && !bus.flush) begin
                    shreg_d = bus.in;
                    tgt_d   = bus.mode;
                    cnt_d   = '0;
                    state_d = NORM_RUN;
                end
            end
            NORM_RUN: begin
                if (bus.flush) begin
                    state_d = NORM_IDLE;
                end else begin
                    shreg_d = shl_fill0(shreg_q, win_cnt);
                    cnt_d   = cnt_q + win_cnt;
                    // A partial window means the first differing bit was found.
                    if ((win_cnt != STEP_L) || (cnt_d == 6'd32)) begin
                        state_d = NORM_DONE;
                    end
                end
            end
            NORM_DONE: begin
                state_d = NORM_IDLE;
                if (!bus.flush) begin
                    count_d = cnt_q;
                    norm_d  = shreg_q;
                end
            end
            default: state_d = NORM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NORM_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
            count_q <= '0;
            norm_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            count_q <= count_d;
            norm_q  <= norm_d;
        end
    end

    // Flush suppresses a result that is being presented this cycle.
    assign done_now  = (state_q == NORM_DONE) && !bus.flush;
    assign bus.ready = (state_q == NORM_IDLE);
    assign bus.done  = done_now;
    assign bus.count = done_now ? cnt_q : count_q;
    assign bus.norm  = done_now ? shreg_q : norm_q;

endmodule

// File: tb/tb_clo_normalizer.sv
// Scoreboard bench driving four normalizers (STEP = 1, 2, 4, 8) side by side.
module tb_clo_normalizer;
    import clo_normalizer_pkg::*;

    typedef struct {
        lzcount_t count;
        word_t    norm;
        int       lat;
        int       c0;
    } exp_t;

    logic     clk = 1'b0;
    int       cyc = 0;
    int       errors = 0;
    int       checks = 0;

    logic [3:0] start_v = '0;
    logic [3:0] flush_v = '0;
    logic [3:0] rst_v   = '1;
    logic       mode_s  = 1'b0;
    word_t      in_s    = '0;

    logic [3:0] ready_v;
    logic [3:0] done_v;
    lzcount_t   count_v [4];
    word_t      norm_v  [4];

    exp_t exp_q [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        clo_normalizer_if nif ();
        assign nif.start  = start_v[g];
        assign nif.mode   = mode_s;
        assign nif.in     = in_s;
        assign nif.flush  = flush_v[g];
        assign ready_v[g] = nif.ready;
        assign done_v[g]  = nif.done;
        assign count_v[g] = nif.count;
        assign norm_v[g]  = nif.norm;

        clo_normalizer #(.STEP(1 << g)) dut (
            .clk   (clk),
            .reset (rst_v[g]),
            .bus   (nif)
        );

        always @(negedge clk) begin
            if (done_v[g]) begin
                if (exp_q[g].size() == 0) begin
                    chk($sformatf("unexpected_done[%0d]", g), 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q[g].pop_front();
                    chk($sformatf("count[%0d]", g), count_v[g], e.count);
                    chk($sformatf("norm[%0d]", g), norm_v[g], e.norm);
                    chk($sformatf("latency[%0d]", g), cyc - e.c0, e.lat);
                end
            end
        end
    end

    function automatic int lat_of(input int k, input int s);
        return (k < 32) ? (k / s + 2) : (32 / s + 1);
    endfunction

    function automatic int ref_lead(input logic md, input word_t val);
        int n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (val[i] != md) break;
            n++;
        end
        return n;
    endfunction

    // Wait (bounded) until every masked DUT is ready, then present one start cycle.
    task automatic issue(input logic [3:0] mask, input logic md, input word_t val,
                         input logic push, input lzcount_t c, input word_t n,
                         input int l0, input int l1, input int l2, input int l3);
        int t = 0;
        int lats [4];
        lats = '{l0, l1, l2, l3};
        while (((ready_v & mask) != mask) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("ready_timeout", 0, 1);
        mode_s  = md;
        in_s    = val;
        start_v = mask;
        if (push) begin
            for (int g = 0; g < 4; g++) begin
                if (mask[g]) exp_q[g].push_back('{count: c, norm: n, lat: lats[g], c0: cyc});
            end
        end
        @(negedge clk);
        start_v = '0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() != 0
                || ready_v != 4'hF) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_v = '0;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("rst_ready[%0d]", g), ready_v[g], 1);
            chk($sformatf("rst_done[%0d]", g), done_v[g], 0);
            chk($sformatf("rst_count[%0d]", g), count_v[g], 0);
            chk($sformatf("rst_norm[%0d]", g), norm_v[g], 0);
        end

        issue(4'hF, 1'b1, 32'hF8A0_0000, 1, 6'd5, 32'h1400_0000, 7, 4, 3, 2);
        wait_idle();
        issue(4'hF, 1'b0, 32'h0000_0001, 1, 6'd31, 32'h8000_0000, 33, 17, 9, 5);
        wait_idle();
        issue(4'hF, 1'b0, 32'h8000_0000, 1, 6'd0, 32'h8000_0000, 2, 2, 2, 2);
        wait_idle();
        issue(4'hF, 1'b1, 32'hFFFF_FFFF, 1, 6'd32, 32'h0, 33, 17, 9, 5);
        wait_idle();
        issue(4'hF, 1'b1, 32'hFFF0_0000, 1, 6'd12, 32'h0, 14, 8, 5, 3);
        wait_idle();
        issue(4'hF, 1'b1, 32'hF8A0_0000, 1, 6'd5, 32'h1400_0000, 7, 4, 3, 2);
        wait_idle();

        // Flush mid-run on the STEP=1 unit keeps the prior result.
        issue(4'b0001, 1'b0, 32'h0000_0001, 0, 6'd0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        flush_v[0] = 1'b1;
        @(negedge clk);
        flush_v[0] = 1'b0;
        chk("flush_ready", ready_v[0], 1);
        chk("flush_count", count_v[0], 5);
        chk("flush_norm", norm_v[0], 32'h1400_0000);

        // Start together with flush in IDLE is rejected.
        mode_s = 1'b1; in_s = 32'hFFFF_FFFF;
        start_v[0] = 1'b1; flush_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; flush_v[0] = 1'b0;
        chk("start_flush_ready", ready_v[0], 1);
        chk("start_flush_count", count_v[0], 5);

        issue(4'b0001, 1'b1, 32'hC000_0000, 1, 6'd2, 32'h0, 4, 0, 0, 0);
        wait_idle();

        // Start while busy is dropped.
        issue(4'b0001, 1'b0, 32'h0000_0001, 1, 6'd31, 32'h8000_0000, 33, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("busy_ready", ready_v[0], 0);
        mode_s = 1'b1; in_s = 32'hFFFF_FFFF; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_idle();
        chk("hold_count", count_v[0], 31);
        chk("hold_norm", norm_v[0], 32'h8000_0000);

        // Reset mid-run.
        issue(4'b0001, 1'b0, 32'h0000_0001, 0, 6'd0, 32'h0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        chk("midrst_ready", ready_v[0], 1);
        chk("midrst_done", done_v[0], 0);
        chk("midrst_count", count_v[0], 0);
        chk("midrst_norm", norm_v[0], 0);

        for (int i = 0; i < 1000; i++) begin
            logic  md;
            word_t val;
            int    k;
            md  = 1'($urandom_range(0, 1));
            val = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 32);
                for (int b = 0; b < 32; b++) begin
                    if (b > 31 - k) val[b] = md;
                    else if (b == 31 - k) val[b] = ~md;
                end
            end
            k = ref_lead(md, val);
            issue(4'hF, md, val, 1, lzcount_t'(k), (k >= 32) ? 32'h0 : (val << k),
                  lat_of(k, 1), lat_of(k, 2), lat_of(k, 4), lat_of(k, 8));
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
